mem_req_ctrl: RTL and testbench
===============================

# mem_req_ctrl

Data-side SRAM-like request controller between the EXE and MEM pipeline stages. It issues load/store requests from EXE onto the `req/addr_ok/data_ok` data SRAM interface and tracks outstanding transactions. Responses are returned to MEM in order. Responses belonging to flushed instructions are discarded. It replaces the fixed-latency data SRAM assumption, so the MEM stage's `ms_ready_go` can key off `ms_data_ok`.

## Interface
- OUTST_MAX, 2, maximum transactions in flight (issued, not yet delivered to MEM); range 1..3
- CNT_W, 2, width of the outstanding and cancel counters; must hold OUTST_MAX
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- es_req_valid  in  1  EXE holds a valid memory op and may issue
- es_req_wr  in  1  1 = store, 0 = load
- es_req_size  in  2  0 = byte, 1 = half, 2 = word
- es_req_addr  in  32  byte address
- es_req_wstrb  in  4  store byte enables
- es_req_wdata  in  32  store data
- es_req_issued  out  1  request accepted this cycle
- ms_data_ok  out  1  response available to MEM
- ms_rdata  out  32  load data for the current MEM op
- ms_ack  in  1  MEM consumes the response (MEM advances to WB)
- flush  in  1  pipeline cancel (exception/ertn)
- data_sram_req, data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb, data_sram_wdata  out  1/1/2/32/4/32  SRAM-like request
- data_sram_addr_ok  in  1  request accepted
- data_sram_data_ok  in  1  response valid
- data_sram_rdata  in  32  response data
- busy  out  1  any transaction in flight, cancel pending, or response buffered

## Operation
- State machine, derived from the counters and registered:
  - IDLE: out_cnt == 0 and cancel_cnt == 0.
  - WAIT: out_cnt > 0.
  - CANCEL: cancel_cnt > 0.
  - Transitions:
    - IDLE→WAIT on issue.
    - WAIT→IDLE when the last data_ok arrives and no issue occurs that cycle.
    - any state→CANCEL on flush when undelivered transactions exist.
    - CANCEL→IDLE when cancel_cnt reaches 0.
- data_sram_req = es_req_valid & ~flush & ~reset & (state != CANCEL) & (out_cnt + fifo_cnt < OUTST_MAX). Request fields pass straight through combinationally.
- es_req_issued = data_sram_req & data_sram_addr_ok.
- out_cnt counter:
  - +1 on issue, −1 on non-discarded data_ok.
  - Both in the same cycle: unchanged.
- Flush:
  - cancel_cnt <= out_cnt − (data_ok this cycle ? 1 : 0).
  - out_cnt <= 0 and the FIFO is cleared.
  - No issue occurs in the flush cycle.
- In CANCEL, each data_ok is dropped (not delivered) and decrements cancel_cnt.
- Delivery, in order:
  - FIFO empty: ms_data_ok = live data_ok and ms_rdata = data_sram_rdata (bypass).
  - FIFO non-empty: delivery comes from the FIFO head.
  - ms_ack pops the head, or consumes the bypass word.
  - A data_ok that is not consumed the same cycle is pushed.
- Stores deliver a response with rdata ignored; MEM still acks it.
- ms_ack while ms_data_ok = 0 is ignored.

## Timing
- Issue is combinational: a request is visible and can be accepted in the cycle es_req_valid rises.
- Response latency to MEM is 0 cycles with bypass, or 1 cycle after data_ok if buffered.
- Reset values:
  - out_cnt, cancel_cnt, fifo_cnt = 0; state IDLE.
  - busy = 0, ms_data_ok = 0, data_sram_req = 0.
- Reset mid-transaction drops all tracking; the SRAM side must also be reset.
- flush and ms_ack in the same cycle: flush wins and nothing is consumed.
- FIFO overflow is impossible by the issue gating. Overflow is an assertion failure.

## Configuration
- MEM_RESP_BUF_EN
  - Defined: FIFO of depth OUTST_MAX holds undelivered responses. MEM may stall arbitrarily.
  - Undefined: no FIFO and fifo_cnt ≡ 0. ms_data_ok = live data_ok only, and MEM must ack in that same cycle. A data_ok with no ms_ack is an assertion failure.

## Structure
- Shared package `mem_pkg`: size encodings (`MEM_SIZE_B/H/W`), state enum (`MRC_IDLE/WAIT/CANCEL`), and the OUTST_MAX default.
- One sub-module `mem_resp_fifo`: a parameterised depth/width sync FIFO with push, pop, clear, count, and head outputs. It is instantiated only under MEM_RESP_BUF_EN.

## Test plan
- Single load: es_req_valid = 1 with addr_ok = 1 → es_req_issued = 1. data_ok arrives 2 cycles later with rdata 0x12345678 → ms_data_ok = 1 and ms_rdata = 0x12345678 in the same cycle; busy returns to 0 after ms_ack.
- Backpressure:
  - Setup: OUTST_MAX = 2, addr_ok held 1, no data_ok.
  - After 2 issues → data_sram_req = 0.
  - One data_ok with ms_ack = 0 → the word is buffered and req stays 0.
  - ms_ack → a new issue is allowed.
- Flush with 2 in flight:
  - flush → cancel_cnt = 2.
  - The next two data_ok pulses (0xAAAA0000, 0xBBBB0000) → ms_data_ok stays 0.
  - A new load after CANCEL→IDLE returns its own data.
- Flush coincident with data_ok, 1 in flight → that response is dropped, cancel_cnt = 0, state IDLE next cycle.
- Ordering: three back-to-back loads returning 1, 2, 3 while MEM stalls 3 cycles → delivered in order 1, 2, 3, one per ms_ack.
- Reset asserted in WAIT with out_cnt = 1 → next cycle state IDLE, busy = 0, data_sram_req = 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-side memory request path: access sizes,
// controller state encoding and the default outstanding-transaction limit.
package mem_pkg;

   localparam logic [1:0] MEM_SIZE_B = 2'd0;
   localparam logic [1:0] MEM_SIZE_H = 2'd1;
   localparam logic [1:0] MEM_SIZE_W = 2'd2;

   localparam int unsigned OUTST_MAX_DEF = 2;

   typedef enum logic [1:0] {
      MRC_IDLE   = 2'd0,
      MRC_WAIT   = 2'd1,
      MRC_CANCEL = 2'd2
   } mrc_state_e;

endpackage

// File: rtl/mem_req_ctrl_if.sv
// SRAM-like data bus (req/addr_ok/data_ok) between the request controller
// (master) and the data SRAM or bridge (slave).
interface mem_req_ctrl_if;

   logic        data_sram_req;
   logic        data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [31:0] data_sram_addr;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_wdata;
   logic        data_sram_addr_ok;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;

   modport master (
      output data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
             data_sram_wstrb, data_sram_wdata,
      input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
   );

   modport slave (
      input  data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
             data_sram_wstrb, data_sram_wdata,
      output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
   );

endinterface

// File: rtl/mem_resp_fifo.sv
// Small synchronous FIFO with clear; head is the oldest entry, count is the
// occupancy. Push while full (without a pop) is a protocol error.
module mem_resp_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             empty;
   logic             full;
   logic             do_push;
   logic             do_pop;

   // Wrapping increment so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   assert property (@(posedge clk) disable iff (reset) !(push && full && !pop));

endmodule

// File: rtl/mem_req_ctrl.sv
// EXE->MEM data request controller: issues loads/stores on the SRAM-like bus,
// tracks in-flight requests, delivers responses in order and drops flushed ones.
// Optional MEM_RESP_BUF_EN adds a response FIFO so MEM may stall on a response.
module mem_req_ctrl
   import mem_pkg::*;
#(
   parameter int unsigned OUTST_MAX = OUTST_MAX_DEF,
   parameter int unsigned CNT_W     = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  es_req_valid,
   input  logic                  es_req_wr,
   input  logic [1:0]            es_req_size,
   input  logic [31:0]           es_req_addr,
   input  logic [3:0]            es_req_wstrb,
   input  logic [31:0]           es_req_wdata,
   output logic                  es_req_issued,
   output logic                  ms_data_ok,
   output logic [31:0]           ms_rdata,
   input  logic                  ms_ack,
   input  logic                  flush,
   mem_req_ctrl_if.master        sram,
   output logic                  busy
);

   localparam int unsigned SUM_W = CNT_W + 1;

   mrc_state_e       state;
   mrc_state_e       state_nxt;
   logic [CNT_W-1:0] out_cnt;
   logic [CNT_W-1:0] out_nxt;
   logic [CNT_W-1:0] cancel_cnt;
   logic [CNT_W-1:0] cancel_nxt;
   logic [CNT_W-1:0] fifo_cnt;
   logic [SUM_W-1:0] inflight;
   logic             live_ok;
   logic             any_ok;

   // Responses only count while something is actually outstanding.
   assign live_ok  = sram.data_sram_data_ok & (state == MRC_WAIT);
   assign any_ok   = sram.data_sram_data_ok & (state != MRC_IDLE);
   assign inflight = SUM_W'(out_cnt) + SUM_W'(fifo_cnt);

   assign sram.data_sram_req   = es_req_valid & ~flush & ~reset & (state != MRC_CANCEL)
                                 & (inflight < SUM_W'(OUTST_MAX));
   assign sram.data_sram_wr    = es_req_wr;
   assign sram.data_sram_size  = es_req_size;
   assign sram.data_sram_addr  = es_req_addr;
   assign sram.data_sram_wstrb = es_req_wstrb;
   assign sram.data_sram_wdata = es_req_wdata;
   assign es_req_issued        = sram.data_sram_req & sram.data_sram_addr_ok;

   assign busy = (out_cnt != '0) || (cancel_cnt != '0) || (fifo_cnt != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= MRC_IDLE;
         out_cnt    <= '0;
         cancel_cnt <= '0;
      end else begin
         state      <= state_nxt;
         out_cnt    <= out_nxt;
         cancel_cnt <= cancel_nxt;
      end
   end

   // Counter update; state is re-derived from the next counter values.
   always_comb begin
      out_nxt    = out_cnt;
      cancel_nxt = cancel_cnt;
      state_nxt  = state;
      if (flush) begin
         // A repeat flush while cancelling keeps the pending drops.
         out_nxt    = '0;
         cancel_nxt = cancel_cnt + out_cnt - CNT_W'(any_ok);
      end else if (state == MRC_CANCEL) begin
         cancel_nxt = cancel_cnt - CNT_W'(sram.data_sram_data_ok);
      end else begin
         out_nxt = out_cnt + CNT_W'(es_req_issued) - CNT_W'(live_ok);
      end
      if (cancel_nxt != '0)   state_nxt = MRC_CANCEL;
      else if (out_nxt != '0) state_nxt = MRC_WAIT;
      else                    state_nxt = MRC_IDLE;
   end

`ifdef MEM_RESP_BUF_EN
   logic [31:0] fifo_head;
   logic        fifo_empty;
   logic        consume;
   logic        push;
   logic        pop;

   // Bypass when nothing is buffered, otherwise present the oldest response.
   assign fifo_empty = (fifo_cnt == '0);
   assign ms_data_ok = ~reset & ~flush & (fifo_empty ? live_ok : 1'b1);
   assign ms_rdata   = fifo_empty ? sram.data_sram_rdata : fifo_head;
   assign consume    = ms_ack & ms_data_ok;
   assign pop        = consume & ~fifo_empty;
   assign push       = live_ok & ~flush & ~reset & ~(consume & fifo_empty);

   mem_resp_fifo #(
      .DEPTH (OUTST_MAX),
      .WIDTH (32),
      .CNT_W (CNT_W)
   ) u_resp_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .clear (flush),
      .wdata (sram.data_sram_rdata),
      .head  (fifo_head),
      .count (fifo_cnt)
   );
`else
   assign fifo_cnt   = '0;
   assign ms_data_ok = ~reset & ~flush & live_ok;
   assign ms_rdata   = sram.data_sram_rdata;

   assert property (@(posedge clk) disable iff (reset) ms_data_ok |-> ms_ack);
`endif

   assert property (@(posedge clk) disable iff (reset)
      sram.data_sram_data_ok |-> (state != MRC_IDLE));
   assert property (@(posedge clk) disable iff (reset)
      sram.data_sram_req |-> ((es_req_size == MEM_SIZE_B) || (es_req_size == MEM_SIZE_H)
                              || (es_req_size == MEM_SIZE_W)));

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl: stimulus queues expected MEM responses,
// a monitor pops and compares them whenever MEM consumes a response.
module tb_mem_req_ctrl;
   import mem_pkg::*;

   typedef struct packed {
      logic        chk;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        es_req_valid;
   logic        es_req_wr;
   logic [1:0]  es_req_size;
   logic [31:0] es_req_addr;
   logic [3:0]  es_req_wstrb;
   logic [31:0] es_req_wdata;
   logic        es_req_issued;
   logic        ms_data_ok;
   logic [31:0] ms_rdata;
   logic        ms_ack;
   logic        flush;
   logic        busy;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   mem_req_ctrl_if sram_bus();

   mem_req_ctrl #(
      .OUTST_MAX (2),
      .CNT_W     (2)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .es_req_valid  (es_req_valid),
      .es_req_wr     (es_req_wr),
      .es_req_size   (es_req_size),
      .es_req_addr   (es_req_addr),
      .es_req_wstrb  (es_req_wstrb),
      .es_req_wdata  (es_req_wdata),
      .es_req_issued (es_req_issued),
      .ms_data_ok    (ms_data_ok),
      .ms_rdata      (ms_rdata),
      .ms_ack        (ms_ack),
      .flush         (flush),
      .sram          (sram_bus),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
      end
   endtask

   task automatic expect_resp(input logic chk, input logic [31:0] d);
      exp_t e;
      e.chk  = chk;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic drive_req(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                            input logic [3:0] wstrb, input logic [31:0] wdata);
      es_req_valid               = 1'b1;
      es_req_wr                  = wr;
      es_req_size                = size;
      es_req_addr                = addr;
      es_req_wstrb               = wstrb;
      es_req_wdata               = wdata;
      sram_bus.data_sram_addr_ok = 1'b1;
   endtask

   task automatic load(input logic [31:0] addr);
      drive_req(1'b0, MEM_SIZE_W, addr, 4'h0, 32'h0);
   endtask

   task automatic resp(input logic [31:0] d);
      sram_bus.data_sram_data_ok = 1'b1;
      sram_bus.data_sram_rdata   = d;
   endtask

   task automatic quiet();
      es_req_valid               = 1'b0;
      sram_bus.data_sram_addr_ok = 1'b0;
      sram_bus.data_sram_data_ok = 1'b0;
      flush                      = 1'b0;
   endtask

   // Scoreboard: every consumed response must match the oldest expectation.
   always @(negedge clk) begin
      if (!reset && ms_data_ok && ms_ack) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL resp_unexpected: got ms_rdata 0x%08h, required no response", ms_rdata);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.chk && (ms_rdata !== mon_e.data)) begin
               errors++;
               $display("FAIL resp_data: got 0x%08h, required 0x%08h", ms_rdata, mon_e.data);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running, required to finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      quiet();
      ms_ack                   = 1'b1;
      es_req_wr                = 1'b0;
      es_req_size              = MEM_SIZE_W;
      es_req_addr              = 32'h0;
      es_req_wstrb             = 4'h0;
      es_req_wdata             = 32'h0;
      sram_bus.data_sram_rdata = 32'h0;
      es_req_valid               = 1'b1;
      sram_bus.data_sram_addr_ok = 1'b1;

      // reset blocks requests and leaves everything idle
      mid();
      check("rst_req", 32'(sram_bus.data_sram_req), 32'd0);
      check("rst_issued", 32'(es_req_issued), 32'd0);
      tick(); tick();
      reset = 1'b0;
      quiet();
      mid();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_state", 32'(dut.state), 32'(MRC_IDLE));
      check("rst_ms_data_ok", 32'(ms_data_ok), 32'd0);

      // single load, response two cycles after issue, bypassed to MEM
      tick(); load(32'h0000_0100); expect_resp(1'b1, 32'h1234_5678);
      mid();
      check("t1_issued", 32'(es_req_issued), 32'd1);
      check("t1_addr", sram_bus.data_sram_addr, 32'h0000_0100);
      tick(); quiet();
      mid(); check("t1_busy_wait", 32'(busy), 32'd1);
      tick(); resp(32'h1234_5678);
      mid();
      check("t1_ms_data_ok", 32'(ms_data_ok), 32'd1);
      check("t1_ms_rdata", ms_rdata, 32'h1234_5678);
      tick(); quiet();
      mid(); check("t1_busy_done", 32'(busy), 32'd0);

      // store + load fill the window, then backpressure
      tick(); drive_req(1'b1, MEM_SIZE_H, 32'h0000_0200, 4'b0011, 32'hCAFE_BEEF);
      expect_resp(1'b0, 32'h0);
      mid();
      check("t2_wr", 32'(sram_bus.data_sram_wr), 32'd1);
      check("t2_wstrb", 32'(sram_bus.data_sram_wstrb), 32'h3);
      check("t2_wdata", sram_bus.data_sram_wdata, 32'hCAFE_BEEF);
      check("t2_size", 32'(sram_bus.data_sram_size), 32'(MEM_SIZE_H));
      tick(); load(32'h0000_0204); expect_resp(1'b1, 32'h2222_2222);
      mid(); check("t2_issue2", 32'(es_req_issued), 32'd1);
      tick();
`ifdef MEM_RESP_BUF_EN
      ms_ack = 1'b0;
`endif
      resp(32'hFFFF_FFFF);
      mid();
      check("t2_full_req", 32'(sram_bus.data_sram_req), 32'd0);
      check("t2_store_ok", 32'(ms_data_ok), 32'd1);
      tick(); sram_bus.data_sram_data_ok = 1'b0;
`ifdef MEM_RESP_BUF_EN
      mid();
      check("t2_buf_req", 32'(sram_bus.data_sram_req), 32'd0);
      check("t2_buf_ok", 32'(ms_data_ok), 32'd1);
      tick(); ms_ack = 1'b1;
      mid(); check("t2_ack_req", 32'(sram_bus.data_sram_req), 32'd0);
      tick();
`endif
      load(32'h0000_0208); expect_resp(1'b1, 32'h3333_3333);
      mid(); check("t2_reissue", 32'(es_req_issued), 32'd1);
      tick(); quiet(); resp(32'h2222_2222);
      mid(); check("t2_drain1", 32'(ms_data_ok), 32'd1);
      tick(); resp(32'h3333_3333);
      tick(); quiet();
      mid(); check("t2_idle", 32'(busy), 32'd0);

      // flush with two in flight: both responses dropped, then a fresh load
      tick(); load(32'h0000_0300);
      mid(); check("t3_issue1", 32'(es_req_issued), 32'd1);
      tick(); load(32'h0000_0304);
      tick(); flush = 1'b1;
      mid(); check("t3_flush_req", 32'(sram_bus.data_sram_req), 32'd0);
      tick(); flush = 1'b0;
      mid();
      check("t3_cancel_cnt", 32'(dut.cancel_cnt), 32'd2);
      check("t3_state", 32'(dut.state), 32'(MRC_CANCEL));
      check("t3_cancel_req", 32'(sram_bus.data_sram_req), 32'd0);
      tick(); resp(32'hAAAA_0000);
      mid(); check("t3_drop1", 32'(ms_data_ok), 32'd0);
      tick(); resp(32'hBBBB_0000);
      mid();
      check("t3_drop2", 32'(ms_data_ok), 32'd0);
      check("t3_drop2_req", 32'(sram_bus.data_sram_req), 32'd0);
      tick(); quiet(); load(32'h0000_0308); expect_resp(1'b1, 32'h5A5A_5A5A);
      mid(); check("t3_new_issue", 32'(es_req_issued), 32'd1);
      tick(); quiet();
      tick(); resp(32'h5A5A_5A5A);
      mid(); check("t3_new_ok", 32'(ms_data_ok), 32'd1);
      tick(); quiet();

      // flush coincident with the only response
      tick(); load(32'h0000_0400);
      mid(); check("t4_issue", 32'(es_req_issued), 32'd1);
      tick(); resp(32'hDEAD_BEEF); flush = 1'b1;
      mid();
      check("t4_drop", 32'(ms_data_ok), 32'd0);
      check("t4_flush_req", 32'(sram_bus.data_sram_req), 32'd0);
      tick(); quiet();
      mid();
      check("t4_cancel_cnt", 32'(dut.cancel_cnt), 32'd0);
      check("t4_state", 32'(dut.state), 32'(MRC_IDLE));
      check("t4_busy", 32'(busy), 32'd0);

      // three loads returning 1, 2, 3 delivered in order
      tick(); load(32'h0000_0500); expect_resp(1'b1, 32'd1);
      tick(); load(32'h0000_0504); expect_resp(1'b1, 32'd2);
      tick(); load(32'h0000_0508); expect_resp(1'b1, 32'd3);
`ifdef MEM_RESP_BUF_EN
      ms_ack = 1'b0;
      resp(32'd1);
      tick(); resp(32'd2);
      tick(); sram_bus.data_sram_data_ok = 1'b0;
      mid();
      check("t5_head", ms_rdata, 32'd1);
      check("t5_stall_req", 32'(sram_bus.data_sram_req), 32'd0);
      tick(); ms_ack = 1'b1;
      mid(); check("t5_pop_req", 32'(sram_bus.data_sram_req), 32'd0);
      tick();
      mid(); check("t5_issue3", 32'(es_req_issued), 32'd1);
      tick(); quiet();
      mid(); check("t5_empty", 32'(ms_data_ok), 32'd0);
      tick(); resp(32'd3);
`else
      resp(32'd1);
      mid(); check("t5_full_req", 32'(sram_bus.data_sram_req), 32'd0);
      tick(); resp(32'd2);
      mid(); check("t5_issue3", 32'(es_req_issued), 32'd1);
      tick(); quiet(); resp(32'd3);
`endif
      tick(); quiet();
      mid(); check("t5_idle", 32'(busy), 32'd0);

      // reset in WAIT drops tracking
      tick(); load(32'h0000_0600);
      mid(); check("t6_issue", 32'(es_req_issued), 32'd1);
      tick(); quiet();
      mid(); check("t6_state_wait", 32'(dut.state), 32'(MRC_WAIT));
      tick(); reset = 1'b1; load(32'h0000_0604);
      mid(); check("t6_rst_req", 32'(sram_bus.data_sram_req), 32'd0);
      tick(); reset = 1'b0; quiet();
      mid();
      check("t6_state_idle", 32'(dut.state), 32'(MRC_IDLE));
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_out_cnt", 32'(dut.out_cnt), 32'd0);

      tick();
      check("end_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
